pipeline_controller: RTL and testbench
======================================

// Module: pipeline_controller
// PURPOSE
//  Parametrised stall/flush/valid controller for the N-stage MIPS pipeline. Replaces hardwired
//  per-latch enables with per-stage enable, flush and valid bits. Resolves I/D-cache waits,
//  load-use hazards, taken-branch squash and halt drain. Sits beside the datapath; drives every
//  pipeline latch enable, cache request strobes and the halt output.
// PARAMETERS
//  NSTAGES    5  pipeline depth; stage 0 = fetch, NSTAGES-1 = writeback; legal 4..8
//  ID_STAGE   1  stage that decodes and resolves branches/jumps
//  EX_STAGE   2  stage that holds the load whose data is not yet available
//  MEM_STAGE  3  stage that issues data-cache requests; must be < NSTAGES-1
//  RADDR_W    5  register-address width
// PORTS
//  CLK          in   1          clock
//  nRST         in   1          reset, asynchronous, active-low
//  ihit         in   1          I-cache returned the instruction this cycle
//  dhit         in   1          D-cache completed the request this cycle
//  mem_ren      in   1          MEM_STAGE instruction is a load
//  mem_wen      in   1          MEM_STAGE instruction is a store
//  mem_halt     in   1          MEM_STAGE instruction is halt or overflow trap
//  ex_ren       in   1          EX_STAGE instruction is a load
//  ex_rdest     in   RADDR_W    EX_STAGE destination register
//  id_rs/id_rt  in   RADDR_W    ID_STAGE source registers
//  id_use_rs/rt in   1          ID_STAGE actually reads rs / rt
//  id_redirect  in   1          ID_STAGE branch taken or jump
//  stage_en     out  NSTAGES    latch enable into stage i
//  stage_flush  out  NSTAGES    load bubble into stage i (only when stage_en[i])
//  stage_valid  out  NSTAGES    stage i holds a real instruction
//  imemREN      out  1          I-cache read request
//  dmemREN/WEN  out  1          D-cache read/write request
//  halt         out  1          processor halted, sticky
// BEHAVIOUR
//  Reset: stage_valid=0, halt=0, FSM=RUN, counters=0; combinational outputs follow from that.
//  FSM RUN -> DRAIN when mem_halt & stage_valid[MEM_STAGE] & advance.
//      DRAIN -> HALTED when stage_valid[NSTAGES-1:MEM_STAGE+1]==0 (older stages retired).
//      HALTED absorbing until nRST. No other transitions.
//  dmemREN = mem_ren & valid[MEM_STAGE] & FSM!=HALTED; dmemWEN likewise; same-cycle, no latch.
//  imemREN = (FSM==RUN); fetch of younger instrs stops immediately on DRAIN.
//  Conditions, strict priority (highest first):
//   1 mem_busy = (dmemREN|dmemWEN) & ~dhit -> stage_en all 0; whole pipe frozen.
//   2 load_use = ex_ren & valid[EX] & ex_rdest!=0 & ((id_use_rs&id_rs==ex_rdest)|
//     (id_use_rt&id_rt==ex_rdest)) -> en[0..ID]=0, en/flush[EX]=1, stages >EX advance.
//   3 ~ihit (RUN) -> en/flush[ID]=1 (bubble), en[0]=0, stages >ID advance.
//   4 id_redirect & valid[ID] -> all en=1, flush[ID]=1 (squash wrong-path fetch).
//   else all en=1, flush=0.
//  Simultaneous redirect with ~ihit: rule 3 applies, redirect PC already in fetch; no extra squash.
//  Simultaneous load_use with redirect: redirect ignored this cycle, re-evaluated next cycle.
//  valid update when en[i]: valid[i] <= flush[i] ? 0 : (i==0 ? ihit&FSM==RUN : valid[i-1]).
//  DRAIN: stages <=MEM_STAGE get flush on advance; valid[NSTAGES-1] clears one cycle after retire.
//  HALTED: stage_en=0, dmem strobes 0, halt=1 (registered, set on the DRAIN->HALTED edge).
//  Reset asserted mid-miss: strobes drop asynchronously; no request left pending.
// CONFIGURATION
//  PIPE_PERF_EN defined: adds outputs stall_cycles, bubble_cycles, retired (32 bit each,
//   wrap-around); stall = rule 1 or 2 cycles, bubble = rule 3 or 4 cycles,
//   retired = cycles with valid[NSTAGES-1]. Counting freezes in HALTED. Undefined: ports absent,
//   no counter logic.
// STRUCTURE
//  cpu_types_pkg: add typedef enum {RUN,DRAIN,HALTED} pipe_state_t and stage_mask_t.
//  One sub-module: hazard_detect (combinational load_use compare), reused by future forwarding.
//  FSM, valid shift register, priority encoder and counters stay in pipeline_controller.
// TESTING
//  Straight-line: ihit=1, no hazards, 8 cycles -> stage_valid fills 00001..11111 by cycle 5.
//  Load-use: ex_ren=1, ex_rdest=5, id_rs=5, id_use_rs=1 -> en=11100, flush[EX]=1 for one cycle.
//  D-miss: dmemREN, dhit low 3 cycles -> stage_en=0 for 3 cycles, valid unchanged, resume on dhit.
//  Branch: id_redirect with ihit=1 -> flush[ID]=1 once; redirect with ihit=0 -> single bubble.
//  Halt: mem_halt at cycle 10 -> imemREN 0 next cycle; halt=1 after MEM..WB drain; sticky 20 cycles.
//  Reset during D-miss: nRST low -> dmemREN/WEN, stage_valid, halt all 0 asynchronously.

Source files
------------

// File: rtl/pipeline_controller_pkg.sv
// Shared types for the pipeline controller slice: FSM state encoding, stage masks
// and performance-counter width.
package pipeline_controller_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pipe_state_t;

    localparam int unsigned MAX_STAGES = 8;
    typedef logic [MAX_STAGES-1:0] stage_mask_t;

    localparam int unsigned PERF_W = 32;
    typedef logic [PERF_W-1:0] perf_cnt_t;

endpackage

// File: rtl/pipeline_controller_if.sv
// Datapath/cache <-> pipeline controller bundle. master = controller side,
// slave = datapath and cache side.
interface pipeline_controller_if #(
    parameter int unsigned NSTAGES = 5,
    parameter int unsigned RADDR_W = 5
);
    logic               ihit;
    logic               dhit;
    logic               mem_ren;
    logic               mem_wen;
    logic               mem_halt;
    logic               ex_ren;
    logic [RADDR_W-1:0] ex_rdest;
    logic [RADDR_W-1:0] id_rs;
    logic [RADDR_W-1:0] id_rt;
    logic               id_use_rs;
    logic               id_use_rt;
    logic               id_redirect;
    logic [NSTAGES-1:0] stage_en;
    logic [NSTAGES-1:0] stage_flush;
    logic [NSTAGES-1:0] stage_valid;
    logic               imemREN;
    logic               dmemREN;
    logic               dmemWEN;
    logic               halt;

    modport master (
        input  ihit, dhit, mem_ren, mem_wen, mem_halt, ex_ren, ex_rdest,
               id_rs, id_rt, id_use_rs, id_use_rt, id_redirect,
        output stage_en, stage_flush, stage_valid, imemREN, dmemREN, dmemWEN, halt
    );

    modport slave (
        output ihit, dhit, mem_ren, mem_wen, mem_halt, ex_ren, ex_rdest,
               id_rs, id_rt, id_use_rs, id_use_rt, id_redirect,
        input  stage_en, stage_flush, stage_valid, imemREN, dmemREN, dmemWEN, halt
    );
endinterface

// File: rtl/pipeline_controller_hazard_detect.sv
// Load-use hazard compare between the EX-stage load destination and the ID-stage
// source registers; register 0 never creates a dependency.
module hazard_detect
    import pipeline_controller_pkg::*;
#(
    parameter int unsigned RADDR_W = 5
) (
    input  logic               ex_ren,
    input  logic               ex_valid,
    input  logic [RADDR_W-1:0] ex_rdest,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic               id_use_rs,
    input  logic               id_use_rt,
    output logic               load_use
);
    logic rs_hit;
    logic rt_hit;

    always_comb begin
        rs_hit   = id_use_rs & (id_rs == ex_rdest);
        rt_hit   = id_use_rt & (id_rt == ex_rdest);
        load_use = ex_ren & ex_valid & (ex_rdest != '0) & (rs_hit | rt_hit);
    end
endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush/valid controller for the N-stage pipeline with RUN/DRAIN/HALTED FSM.
// Optional performance counters are built when PIPE_PERF_EN is defined.
module pipeline_controller
    import pipeline_controller_pkg::*;
#(
    parameter int unsigned NSTAGES   = 5,
    parameter int unsigned ID_STAGE  = 1,
    parameter int unsigned EX_STAGE  = 2,
    parameter int unsigned MEM_STAGE = 3,
    parameter int unsigned RADDR_W   = 5
) (
    input  logic                 CLK,
    input  logic                 nRST,
    pipeline_controller_if.master bus
`ifdef PIPE_PERF_EN
    ,
    output perf_cnt_t            stall_cycles,
    output perf_cnt_t            bubble_cycles,
    output perf_cnt_t            retired
`endif
);
    pipe_state_t        state_q, state_d;
    logic               halt_q, halt_d;
    logic [NSTAGES-1:0] valid_q, valid_d;
    logic [NSTAGES-1:0] en, flush, shift_in;
    logic               dmem_ren, dmem_wen, mem_busy, load_use, go_drain, fetch_valid;

    hazard_detect #(.RADDR_W(RADDR_W)) u_hazard (
        .ex_ren    (bus.ex_ren),
        .ex_valid  (valid_q[EX_STAGE]),
        .ex_rdest  (bus.ex_rdest),
        .id_rs     (bus.id_rs),
        .id_rt     (bus.id_rt),
        .id_use_rs (bus.id_use_rs),
        .id_use_rt (bus.id_use_rt),
        .load_use  (load_use)
    );

    // Strobes are purely combinational on valid_q, so an async reset drops them at once.
    always_comb begin
        dmem_ren = bus.mem_ren & valid_q[MEM_STAGE] & (state_q != HALTED);
        dmem_wen = bus.mem_wen & valid_q[MEM_STAGE] & (state_q != HALTED);
        mem_busy = (dmem_ren | dmem_wen) & ~bus.dhit;
    end

    always_comb begin
        en    = '1;
        flush = '0;
        if (state_q == HALTED) begin
            en = '0;
        end else if (mem_busy) begin
            en = '0;
        end else if (load_use) begin
            for (int unsigned i = 0; i < EX_STAGE; i++) en[i] = 1'b0;
            flush[EX_STAGE] = 1'b1;
        end else if (~bus.ihit && (state_q == RUN)) begin
            for (int unsigned i = 0; i < ID_STAGE; i++) en[i] = 1'b0;
            flush[ID_STAGE] = 1'b1;
        end else if (bus.id_redirect && valid_q[ID_STAGE]) begin
            flush[ID_STAGE] = 1'b1;
        end
        go_drain = (state_q == RUN) & bus.mem_halt & valid_q[MEM_STAGE] & en[MEM_STAGE];
        // Younger instructions are killed on the same edge the halt leaves MEM,
        // so nothing behind it ever reaches the stages past MEM.
        if ((state_q == DRAIN) || go_drain) begin
            for (int unsigned i = 0; i <= MEM_STAGE; i++) flush[i] = flush[i] | en[i];
        end
    end

    always_comb begin
        fetch_valid = bus.ihit & (state_q == RUN);
        shift_in    = {valid_q[NSTAGES-2:0], fetch_valid};
        valid_d     = (en & ~flush & shift_in) | (~en & valid_q);
    end

    always_comb begin
        state_d = state_q;
        halt_d  = halt_q;
        case (state_q)
            RUN: begin
                if (go_drain) state_d = DRAIN;
            end
            DRAIN: begin
                if (valid_q[NSTAGES-1:MEM_STAGE+1] == '0) begin
                    state_d = HALTED;
                    halt_d  = 1'b1;
                end
            end
            HALTED: state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            halt_q  <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
            valid_q <= valid_d;
        end
    end

    assign bus.stage_en    = en;
    assign bus.stage_flush = flush;
    assign bus.stage_valid = valid_q;
    assign bus.imemREN     = (state_q == RUN);
    assign bus.dmemREN     = dmem_ren;
    assign bus.dmemWEN     = dmem_wen;
    assign bus.halt        = halt_q;

`ifdef PIPE_PERF_EN
    perf_cnt_t stall_q, stall_d, bubble_q, bubble_d, retired_q, retired_d;
    logic      is_stall, is_bubble;

    always_comb begin
        is_stall  = mem_busy | load_use;
        is_bubble = ~is_stall & ((~bus.ihit & (state_q == RUN)) |
                                 (bus.id_redirect & valid_q[ID_STAGE]));
        stall_d   = stall_q;
        bubble_d  = bubble_q;
        retired_d = retired_q;
        if (state_q != HALTED) begin
            if (is_stall)             stall_d   = stall_q + 1'b1;
            if (is_bubble)            bubble_d  = bubble_q + 1'b1;
            if (valid_q[NSTAGES-1])   retired_d = retired_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q   <= '0;
            bubble_q  <= '0;
            retired_q <= '0;
        end else begin
            stall_q   <= stall_d;
            bubble_q  <= bubble_d;
            retired_q <= retired_d;
        end
    end

    assign stall_cycles  = stall_q;
    assign bubble_cycles = bubble_q;
    assign retired       = retired_q;
`endif
endmodule

// File: tb/tb_pipeline_controller.sv
// Table-driven bench for pipeline_controller (5 stages, ID=1, EX=2, MEM=3) plus
// hand sequences for halt drain and reset during a D-cache miss.
module tb_pipeline_controller;
    localparam int unsigned NS = 5;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    pipeline_controller_if #(.NSTAGES(NS), .RADDR_W(5)) bus ();

`ifdef PIPE_PERF_EN
    logic [31:0] stall_cycles, bubble_cycles, retired;
`endif

    pipeline_controller #(
        .NSTAGES(NS), .ID_STAGE(1), .EX_STAGE(2), .MEM_STAGE(3), .RADDR_W(5)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
`ifdef PIPE_PERF_EN
        ,
        .stall_cycles  (stall_cycles),
        .bubble_cycles (bubble_cycles),
        .retired       (retired)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       ihit, dhit, mem_ren, mem_wen, ex_ren;
        logic [4:0] ex_rdest, id_rs, id_rt;
        logic       use_rs, use_rt, redirect;
        logic [4:0] en, fl, vl;
        logic       dr, dw;
    } vec_t;

    int   n_pass  = 0;
    int   n_total = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input logic ih, dh, mr, mw, er,
                                input logic [4:0] rd, rs, rt,
                                input logic urs, urt, red,
                                input logic [4:0] en, fl, vl,
                                input logic dr, dw);
        vec_t v;
        v.ihit = ih; v.dhit = dh; v.mem_ren = mr; v.mem_wen = mw; v.ex_ren = er;
        v.ex_rdest = rd; v.id_rs = rs; v.id_rt = rt;
        v.use_rs = urs; v.use_rt = urt; v.redirect = red;
        v.en = en; v.fl = fl; v.vl = vl; v.dr = dr; v.dw = dw;
        return v;
    endfunction

    function automatic vec_t plain(input logic [4:0] vl);
        return mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, vl, 0, 0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        bus.ihit = v.ihit; bus.dhit = v.dhit; bus.mem_ren = v.mem_ren; bus.mem_wen = v.mem_wen;
        bus.ex_ren = v.ex_ren; bus.ex_rdest = v.ex_rdest; bus.id_rs = v.id_rs; bus.id_rt = v.id_rt;
        bus.id_use_rs = v.use_rs; bus.id_use_rt = v.use_rt; bus.id_redirect = v.redirect;
        bus.mem_halt = 1'b0;
    endtask

    task automatic idle();
        drive(plain(5'b00000));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t e;
        int   w;

        idle();
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset_valid", 32'(bus.stage_valid), 32'h0);
        check("reset_halt",  32'(bus.halt), 32'h0);
        check("reset_en",    32'(bus.stage_en), 32'h1f);
        check("reset_imem",  32'(bus.imemREN), 32'h1);
        check("reset_dmem",  32'({bus.dmemREN, bus.dmemWEN}), 32'h0);
        @(posedge CLK); #1;
        nRST = 1'b1;

        // straight-line fill
        tbl.push_back(plain(5'b00000));
        tbl.push_back(plain(5'b00001));
        tbl.push_back(plain(5'b00011));
        tbl.push_back(plain(5'b00111));
        tbl.push_back(plain(5'b01111));
        tbl.push_back(plain(5'b11111));
        tbl.push_back(plain(5'b11111));
        tbl.push_back(plain(5'b11111));
        // load-use on rs, then one normal cycle
        tbl.push_back(mk(1,1,0,0,1, 5,5,0, 1,0,0, 5'b11100,5'b00100,5'b11111, 0,0));
        tbl.push_back(plain(5'b11011));
        // r0 destination never hazards
        tbl.push_back(mk(1,1,0,0,1, 0,0,0, 0,1,0, 5'b11111,5'b00000,5'b10111, 0,0));
        // load-use on rt
        tbl.push_back(mk(1,1,0,0,1, 7,3,7, 1,1,0, 5'b11100,5'b00100,5'b01111, 0,0));
        // same regs but EX bubble -> no hazard
        tbl.push_back(mk(1,1,0,0,1, 7,3,7, 1,1,0, 5'b11111,5'b00000,5'b11011, 0,0));
        // matching rs but not read
        tbl.push_back(mk(1,1,0,0,1, 9,9,0, 0,0,0, 5'b11111,5'b00000,5'b10111, 0,0));
        // I-miss bubble
        tbl.push_back(mk(0,1,0,0,0, 0,0,0, 0,0,0, 5'b11110,5'b00010,5'b01111, 0,0));
        // redirect with invalid ID ignored; then valid redirect squashes
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 0,0,1, 5'b11111,5'b00000,5'b11101, 0,0));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 0,0,1, 5'b11111,5'b00010,5'b11011, 0,0));
        // redirect with I-miss: single bubble
        tbl.push_back(mk(0,1,0,0,0, 0,0,0, 0,0,1, 5'b11110,5'b00010,5'b10101, 0,0));
        tbl.push_back(plain(5'b01001));
        tbl.push_back(plain(5'b10011));
        // load-use beats redirect, redirect taken next cycle
        tbl.push_back(mk(1,1,0,0,1, 4,4,0, 1,0,1, 5'b11100,5'b00100,5'b00111, 0,0));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 0,0,1, 5'b11111,5'b00010,5'b01011, 0,0));
        // load-use beats I-miss
        tbl.push_back(mk(0,1,0,0,1, 6,6,0, 1,0,0, 5'b11100,5'b00100,5'b10101, 0,0));
        tbl.push_back(plain(5'b01001));
        tbl.push_back(plain(5'b10011));
        tbl.push_back(plain(5'b00111));
        tbl.push_back(plain(5'b01111));
        tbl.push_back(mk(0,1,0,0,0, 0,0,0, 0,0,0, 5'b11110,5'b00010,5'b11111, 0,0));
        // D-miss 3 cycles: store, then load+load_use+imiss, then load; resume on dhit
        tbl.push_back(mk(1,0,0,1,0, 0,0,0, 0,0,0, 5'b00000,5'b00000,5'b11101, 0,1));
        tbl.push_back(mk(0,0,1,0,1, 5,5,0, 1,0,0, 5'b00000,5'b00000,5'b11101, 1,0));
        tbl.push_back(mk(1,0,1,0,0, 0,0,0, 0,0,0, 5'b00000,5'b00000,5'b11101, 1,0));
        tbl.push_back(mk(1,1,1,0,0, 0,0,0, 0,0,0, 5'b11111,5'b00000,5'b11101, 1,0));
        tbl.push_back(plain(5'b11011));
        // MEM bubble: no strobes, no stall despite dhit low
        tbl.push_back(mk(1,0,1,1,0, 0,0,0, 0,0,0, 5'b11111,5'b00000,5'b10111, 0,0));

        foreach (tbl[i]) begin
            drive(tbl[i]);
            exp_q.push_back(tbl[i]);
            @(negedge CLK);
            e = exp_q.pop_front();
            check($sformatf("row%0d_en", i),    32'(bus.stage_en),    32'(e.en));
            check($sformatf("row%0d_flush", i), 32'(bus.stage_flush), 32'(e.fl));
            check($sformatf("row%0d_valid", i), 32'(bus.stage_valid), 32'(e.vl));
            check($sformatf("row%0d_dren", i),  32'(bus.dmemREN),     32'(e.dr));
            check($sformatf("row%0d_dwen", i),  32'(bus.dmemWEN),     32'(e.dw));
            check($sformatf("row%0d_status", i), 32'({bus.imemREN, bus.halt}), 32'h2);
            @(posedge CLK); #1;
        end

        // halt drain
        idle();
        @(posedge CLK); #1;
        bus.mem_halt = 1'b1;
        @(negedge CLK);
        check("halt_cycle_valid", 32'(bus.stage_valid), 32'h1f);
        check("halt_cycle_en",    32'(bus.stage_en), 32'h1f);
        check("halt_cycle_imem",  32'(bus.imemREN), 32'h1);
        @(posedge CLK); #1;
        bus.mem_halt = 1'b0;
        @(negedge CLK);
        check("drain_imem",     32'(bus.imemREN), 32'h0);
        check("drain_halt_low", 32'(bus.halt), 32'h0);
        check("drain_flush",    32'(bus.stage_flush), 32'h0f);
        w = 0;
        while (bus.halt !== 1'b1 && w < 8) begin
            @(negedge CLK);
            w++;
        end
        check("halt_reached",  32'(bus.halt), 32'h1);
        check("halted_valid",  32'(bus.stage_valid), 32'h0);
        check("halted_en",     32'(bus.stage_en), 32'h0);
        bus.mem_ren = 1'b1; bus.mem_wen = 1'b1; bus.dhit = 1'b0; bus.ihit = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            check($sformatf("halt_sticky%0d", k),
                  32'({bus.halt, bus.dmemREN, bus.dmemWEN, bus.imemREN, bus.stage_en}), 32'h100);
        end

        // async reset out of HALTED
        #2 nRST = 1'b0;
        #1;
        check("rst_halt",  32'(bus.halt), 32'h0);
        check("rst_valid", 32'(bus.stage_valid), 32'h0);
        check("rst_imem",  32'(bus.imemREN), 32'h1);
        idle();
        @(posedge CLK); #1;
        nRST = 1'b1;
        repeat (5) begin @(posedge CLK); #1; end

        // reset asserted mid D-miss
        bus.mem_ren = 1'b1; bus.mem_wen = 1'b1; bus.dhit = 1'b0;
        @(negedge CLK);
        check("miss_strobes", 32'({bus.dmemREN, bus.dmemWEN}), 32'h3);
        check("miss_en",      32'(bus.stage_en), 32'h0);
        check("miss_valid",   32'(bus.stage_valid), 32'h1f);
        #2 nRST = 1'b0;
        #1;
        check("rst_miss_strobes", 32'({bus.dmemREN, bus.dmemWEN}), 32'h0);
        check("rst_miss_valid",   32'(bus.stage_valid), 32'h0);
        check("rst_miss_halt",    32'(bus.halt), 32'h0);
        @(posedge CLK); #1;
        check("rst_hold_strobes", 32'({bus.dmemREN, bus.dmemWEN}), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
